single_to_ext_batch_sequencer: RTL and testbench

Multi-channel front end for the control-system single→extended-single converter in the FPGA_WT datapath. On a start pulse it snapshots a bank of `N_CH` single-precision control signals and streams them one per clock into the external pipelined converter. It tags each issued word so the converted results land in the right output slot. When the batch completes it publishes the whole extended-single bank atomically, with a one-cycle done pulse.

---
 rtl/single_to_ext_batch_sequencer_pkg.sv | 24 ++
 rtl/single_to_ext_batch_sequencer_if.sv | 29 ++
 rtl/single_to_ext_batch_sequencer_conv_tag_pipe.sv | 40 ++++
 rtl/single_to_ext_batch_sequencer.sv | 144 ++++++++++++++
 tb/tb_single_to_ext_batch_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/single_to_ext_batch_sequencer_pkg.sv
// Shared widths, state type and helpers for the single->extended-single batch sequencer.
package single_to_ext_batch_sequencer_pkg;

    localparam int unsigned SINGLE          = 32;
    localparam int unsigned EXTENDED_SINGLE = 43;
    localparam int unsigned CONV_LAT_DFLT   = 2;
    localparam int unsigned IDX_MAX_W       = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_PUBLISH
    } seq_state_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [IDX_MAX_W-1:0] lsb_idx(input logic [31:0] m);
        lsb_idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (m[i]) lsb_idx = IDX_MAX_W'(i);
        end
    endfunction

endpackage

// File: rtl/single_to_ext_batch_sequencer_if.sv
// Bus bundle between the batch sequencer, its client and the external converter.
// SEQ_CH_MASK_EN adds the per-batch channel mask.
interface single_to_ext_batch_sequencer_if
    import single_to_ext_batch_sequencer_pkg::*;
#(
    parameter int unsigned N_CH = 8
);
    logic                            sta;
    logic [N_CH*SINGLE-1:0]          x_bus;
    logic [SINGLE-1:0]               conv_x;
    logic [EXTENDED_SINGLE-1:0]      conv_y;
    logic [N_CH*EXTENDED_SINGLE-1:0] y_bus;
    logic                            done_sig;
    logic                            busy;
    logic                            overrun;
`ifdef SEQ_CH_MASK_EN
    logic [N_CH-1:0]                 ch_mask;

    modport master (output sta, x_bus, conv_y, ch_mask,
                    input  conv_x, y_bus, done_sig, busy, overrun);
    modport slave  (input  sta, x_bus, conv_y, ch_mask,
                    output conv_x, y_bus, done_sig, busy, overrun);
`else
    modport master (output sta, x_bus, conv_y,
                    input  conv_x, y_bus, done_sig, busy, overrun);
    modport slave  (input  sta, x_bus, conv_y,
                    output conv_x, y_bus, done_sig, busy, overrun);
`endif
endinterface

// File: rtl/single_to_ext_batch_sequencer_conv_tag_pipe.sv
// Tag shift register tracking which result slot each converter output belongs to.
module conv_tag_pipe #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned IW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_valid,
    input  logic [IW-1:0] push_idx,
    output logic          tail_valid,
    output logic [IW-1:0] tail_idx,
    output logic          any_valid_c
);
    logic [DEPTH-1:0] vld_q;
    logic [IW-1:0]    idx_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) idx_q[i] <= '0;
        end else begin
            vld_q[0] <= push_valid;
            idx_q[0] <= push_idx;
            for (int i = 1; i < int'(DEPTH); i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    // Valid tags still in flight after the tail is consumed this cycle.
    always_comb begin
        any_valid_c = 1'b0;
        for (int i = 0; i < int'(DEPTH) - 1; i++) any_valid_c = any_valid_c | vld_q[i];
    end

    assign tail_valid = vld_q[DEPTH-1];
    assign tail_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/single_to_ext_batch_sequencer.sv
// Snapshots N_CH singles, streams them through the external converter, publishes the bank atomically.
// SEQ_CH_MASK_EN enables skipping channels via ch_mask.
module single_to_ext_batch_sequencer
    import single_to_ext_batch_sequencer_pkg::*;
#(
    parameter int unsigned N_CH     = 8,
    parameter int unsigned CONV_LAT = CONV_LAT_DFLT
) (
    input logic                            clk,
    input logic                            rst,
    single_to_ext_batch_sequencer_if.slave bus
);
    localparam int unsigned SW = SINGLE;
    localparam int unsigned EW = EXTENDED_SINGLE;
    localparam int unsigned IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    seq_state_t           state_q, state_d;
    logic [N_CH*SW-1:0]   shadow_q, shadow_d;
    logic [N_CH*EW-1:0]   res_q, res_d;
    logic [N_CH*EW-1:0]   y_q, y_d;
    logic [N_CH-1:0]      pend_q, pend_d;
    logic [N_CH-1:0]      mask_in;
    logic [IW-1:0]        cnt_q, cnt_d;
    logic [SW-1:0]        conv_x_q, conv_x_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic                 push_valid;
    logic                 tail_valid;
    logic                 any_valid_c;
    logic [IW-1:0]        tail_idx;
    logic [IDX_MAX_W-1:0] first_idx, next_idx;

`ifdef SEQ_CH_MASK_EN
    assign mask_in = bus.ch_mask;
`else
    assign mask_in = '1;
`endif

    assign first_idx = lsb_idx(32'(mask_in));
    assign next_idx  = lsb_idx(32'(pend_q));

    conv_tag_pipe #(.DEPTH(CONV_LAT), .IW(IW)) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_idx   (cnt_q),
        .tail_valid (tail_valid),
        .tail_idx   (tail_idx),
        .any_valid_c(any_valid_c)
    );

    // conv_x is preloaded one cycle ahead so channel k sits on it while its tag is pushed.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        res_d      = res_q;
        y_d        = y_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        conv_x_d   = conv_x_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        overrun_d  = overrun_q;
        push_valid = 1'b0;

        if (tail_valid) res_d[32'(tail_idx)*EW +: EW] = bus.conv_y;
        if (bus.sta && busy_q) overrun_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus.sta) begin
                    shadow_d = bus.x_bus;
                    busy_d   = 1'b1;
                    if (mask_in == '0) begin
                        state_d = S_PUBLISH;
                        done_d  = 1'b1;
                        y_d     = res_d;
                    end else begin
                        cnt_d    = IW'(first_idx);
                        pend_d   = mask_in & ~(N_CH'(1) << first_idx);
                        conv_x_d = bus.x_bus[32'(first_idx)*SW +: SW];
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                push_valid = 1'b1;
                if (pend_q == '0) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d    = IW'(next_idx);
                    pend_d   = pend_q & ~(N_CH'(1) << next_idx);
                    conv_x_d = shadow_q[32'(next_idx)*SW +: SW];
                end
            end
            S_DRAIN: begin
                if (!any_valid_c) begin
                    state_d = S_PUBLISH;
                    done_d  = 1'b1;
                    y_d     = res_d;
                end
            end
            S_PUBLISH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            shadow_q  <= '0;
            res_q     <= '0;
            y_q       <= '0;
            pend_q    <= '0;
            cnt_q     <= '0;
            conv_x_q  <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            res_q     <= res_d;
            y_q       <= y_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            conv_x_q  <= conv_x_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.conv_x   = conv_x_q;
    assign bus.y_bus    = y_q;
    assign bus.done_sig = done_q;
    assign bus.busy     = busy_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_single_to_ext_batch_sequencer.sv
// Bench for single_to_ext_batch_sequencer with a pipelined converter model and bank-level reference.
// Define SEQ_CH_MASK_EN to also exercise channel masking.
module tb_single_to_ext_batch_sequencer;
    import single_to_ext_batch_sequencer_pkg::*;

    localparam int unsigned N_CH = 8;
    localparam int unsigned LAT  = CONV_LAT_DFLT;
    localparam int unsigned SW   = SINGLE;
    localparam int unsigned EW   = EXTENDED_SINGLE;
    localparam int unsigned XW   = N_CH*SW;
    localparam int unsigned YW   = N_CH*EW;
    localparam int          MAXC = 40;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    single_to_ext_batch_sequencer_if #(.N_CH(N_CH)) bus ();

    single_to_ext_batch_sequencer #(.N_CH(N_CH), .CONV_LAT(LAT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Reference single -> extended-single (1/11/31) conversion.
    function automatic logic [EW-1:0] conv_f(input logic [SW-1:0] s);
        logic [10:0] e;
        if (s[30:23] == 8'd0) return {s[31], 42'd0};
        e = (s[30:23] == 8'hFF) ? 11'h7FF : 11'(s[30:23]) + 11'd896;
        return {s[31], e, s[22:0], 8'd0};
    endfunction

    // Fixed-latency converter model.
    logic [EW-1:0] cpipe [LAT];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(LAT); i++) cpipe[i] <= '0;
        end else begin
            cpipe[0] <= conv_f(bus.conv_x);
            for (int i = 1; i < int'(LAT); i++) cpipe[i] <= cpipe[i-1];
        end
    end
    assign bus.conv_y = cpipe[LAT-1];

    function automatic logic [XW-1:0] rand_x();
        logic [XW-1:0] x;
        for (int k = 0; k < int'(N_CH); k++) x[k*SW +: SW] = $urandom();
        return x;
    endfunction

    function automatic logic [YW-1:0] model_bank(input logic [XW-1:0] x, input logic [N_CH-1:0] m,
                                                 input logic [YW-1:0] prev);
        logic [YW-1:0] y;
        y = prev;
        for (int k = 0; k < int'(N_CH); k++)
            if (m[k]) y[k*EW +: EW] = conv_f(x[k*SW +: SW]);
        return y;
    endfunction

    function automatic int model_done(input logic [N_CH-1:0] m);
        int p;
        p = $countones(m);
        return (p == 0) ? 1 : p + int'(LAT) + 1;
    endfunction

    logic [YW-1:0]   exp_y;
    logic [N_CH-1:0] last_mask;

    // Observations from one watched batch, cycle numbers relative to the sta cycle.
    int            w_done_cyc, w_done_n, w_busy_lo, w_busy_hi, w_busy_n;
    bit            w_y_early;
    logic [YW-1:0] w_y_done;
    logic [SW-1:0] w_cx [MAXC];

    task automatic start(input logic [XW-1:0] x, input logic [N_CH-1:0] m);
        bus.x_bus = x;
        last_mask = m;
`ifdef SEQ_CH_MASK_EN
        bus.ch_mask = m;
`endif
        bus.sta = 1'b1;
        @(posedge clk); #1;
        bus.sta = 1'b0;
    endtask

    task automatic watch(input int ncyc, input logic [YW-1:0] y_prev, input int sta_at,
                         input int xchg_at, input logic [XW-1:0] xnew, input int rst_lo, input int rst_hi);
        w_done_cyc = -1; w_done_n = 0; w_busy_lo = -1; w_busy_hi = -1; w_busy_n = 0;
        w_y_early = 1'b0; w_y_done = '0;
        for (int c = 1; c <= ncyc; c++) begin
            w_cx[c] = bus.conv_x;
            if (bus.done_sig === 1'b1) begin
                if (w_done_n == 0) begin w_done_cyc = c; w_y_done = bus.y_bus; end
                w_done_n++;
            end
            if (bus.busy === 1'b1) begin
                if (w_busy_lo < 0) w_busy_lo = c;
                w_busy_hi = c;
                w_busy_n++;
            end
            if (w_done_n == 0 && bus.y_bus !== y_prev) w_y_early = 1'b1;
            bus.sta = (c == sta_at);
            if (c == xchg_at) bus.x_bus = xnew;
            if (c == rst_lo) rst = 1'b0;
            if (c == rst_hi) rst = 1'b1;
            @(posedge clk); #1;
        end
        bus.sta = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.conv_x !== '0) begin failures++; $display("FAIL reset_conv_x got=%h want=0", bus.conv_x); end
        checks++; if (bus.y_bus !== '0) begin failures++; $display("FAIL reset_y_bus got=%h want=0", bus.y_bus); end
        checks++; if (bus.done_sig !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done_sig); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b want=0", bus.overrun); end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_basic();
        logic [XW-1:0] x;
        logic [YW-1:0] e;
        x = '0;
        x[0 +: SW]  = 32'h3F80_0000;
        x[SW +: SW] = 32'hC000_0000;
        e = model_bank(x, '1, exp_y);
        start(x, '1);
        watch(14, exp_y, -1, -1, '0, -1, -1);
        checks++; if (w_done_cyc != 11) begin failures++; $display("FAIL basic_done_cycle got=%0d want=11", w_done_cyc); end
        checks++; if (w_done_n != 1) begin failures++; $display("FAIL basic_done_count got=%0d want=1", w_done_n); end
        checks++; if (w_busy_lo != 1 || w_busy_hi != 11 || w_busy_n != 11) begin
            failures++; $display("FAIL basic_busy got=%0d..%0d n=%0d want=1..11 n=11", w_busy_lo, w_busy_hi, w_busy_n); end
        checks++; if (w_y_early) begin failures++; $display("FAIL basic_y_early got=changed want=stable"); end
        checks++; if (w_y_done[0 +: EW] !== 43'h1FF_8000_0000) begin
            failures++; $display("FAIL basic_slot0 got=%h want=1ff80000000", w_y_done[0 +: EW]); end
        checks++; if (w_y_done[EW +: EW] !== 43'h600_0000_0000) begin
            failures++; $display("FAIL basic_slot1 got=%h want=60000000000", w_y_done[EW +: EW]); end
        checks++; if (w_y_done !== e) begin failures++; $display("FAIL basic_bank got=%h want=%h", w_y_done, e); end
        for (int k = 0; k < int'(N_CH); k++) begin
            checks++; if (w_cx[1+k] !== x[k*SW +: SW]) begin
                failures++; $display("FAIL basic_conv_x ch=%0d got=%h want=%h", k, w_cx[1+k], x[k*SW +: SW]); end
        end
        checks++; if (bus.y_bus !== e) begin failures++; $display("FAIL basic_y_hold got=%h want=%h", bus.y_bus, e); end
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL basic_overrun got=%b want=0", bus.overrun); end
        exp_y = e;
    endtask

    task automatic test_x_change();
        logic [XW-1:0] x, xn;
        logic [YW-1:0] e;
        x = rand_x(); xn = rand_x();
        e = model_bank(x, '1, exp_y);
        start(x, '1);
        watch(12, exp_y, -1, 1, xn, -1, -1);
        checks++; if (w_done_cyc != 11) begin failures++; $display("FAIL xchg_done_cycle got=%0d want=11", w_done_cyc); end
        checks++; if (w_y_done !== e) begin failures++; $display("FAIL xchg_bank got=%h want=%h", w_y_done, e); end
        for (int k = 0; k < int'(N_CH); k++) begin
            checks++; if (w_cx[1+k] !== x[k*SW +: SW]) begin
                failures++; $display("FAIL xchg_conv_x ch=%0d got=%h want=%h", k, w_cx[1+k], x[k*SW +: SW]); end
        end
        exp_y = e;
    endtask

    task automatic test_back_to_back();
        logic [XW-1:0] x1, x2;
        logic [YW-1:0] e1, e2;
        x1 = rand_x(); x2 = rand_x();
        e1 = model_bank(x1, '1, exp_y);
        e2 = model_bank(x2, '1, e1);
        start(x1, '1);
        watch(11, exp_y, -1, -1, '0, -1, -1);
        checks++; if (w_done_cyc != 11 || w_y_done !== e1) begin
            failures++; $display("FAIL b2b_first got=%0d/%h want=11/%h", w_done_cyc, w_y_done, e1); end
        start(x2, '1);
        watch(13, e1, -1, -1, '0, -1, -1);
        checks++; if (w_done_cyc + 12 != 23) begin failures++; $display("FAIL b2b_done_cycle got=%0d want=23", w_done_cyc + 12); end
        checks++; if (w_y_early) begin failures++; $display("FAIL b2b_y_hold got=changed want=batch1 through 22"); end
        checks++; if (w_y_done !== e2) begin failures++; $display("FAIL b2b_bank got=%h want=%h", w_y_done, e2); end
        checks++; if (w_busy_lo != 1 || w_busy_hi != 11) begin
            failures++; $display("FAIL b2b_busy got=%0d..%0d want=1..11", w_busy_lo, w_busy_hi); end
        exp_y = e2;
    endtask

    task automatic test_overrun();
        logic [XW-1:0] x;
        logic [YW-1:0] e;
        x = rand_x();
        e = model_bank(x, '1, exp_y);
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL ovr_pre got=%b want=0", bus.overrun); end
        start(x, '1);
        watch(15, exp_y, 5, -1, '0, -1, -1);
        checks++; if (w_done_cyc != 11 || w_done_n != 1) begin
            failures++; $display("FAIL ovr_done got=%0d n=%0d want=11 n=1", w_done_cyc, w_done_n); end
        checks++; if (w_y_done !== e) begin failures++; $display("FAIL ovr_bank got=%h want=%h", w_y_done, e); end
        checks++; if (w_busy_hi != 11) begin failures++; $display("FAIL ovr_busy_end got=%0d want=11", w_busy_hi); end
        checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b want=1", bus.overrun); end
        exp_y = e;
    endtask

    task automatic test_mid_reset();
        logic [XW-1:0] x;
        logic [YW-1:0] e;
        x = rand_x();
        start(x, '1);
        watch(14, exp_y, -1, -1, '0, 6, 8);
        checks++; if (w_done_n != 0) begin failures++; $display("FAIL rst_no_done got=%0d want=0", w_done_n); end
        checks++; if (bus.y_bus !== '0) begin failures++; $display("FAIL rst_y_bus got=%h want=0", bus.y_bus); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun got=%b want=0", bus.overrun); end
        checks++; if (bus.conv_x !== '0) begin failures++; $display("FAIL rst_conv_x got=%h want=0", bus.conv_x); end
        exp_y = '0;
        x = rand_x();
        e = model_bank(x, '1, exp_y);
        start(x, '1);
        watch(12, exp_y, -1, -1, '0, -1, -1);
        checks++; if (w_done_cyc != 11 || w_y_done !== e) begin
            failures++; $display("FAIL rst_fresh got=%0d/%h want=11/%h", w_done_cyc, w_y_done, e); end
        exp_y = e;
    endtask

    task automatic test_publish_sta();
        logic [XW-1:0] x;
        logic [YW-1:0] e;
        x = rand_x();
        e = model_bank(x, '1, exp_y);
        start(x, '1);
        watch(16, exp_y, 11, -1, '0, -1, -1);
        checks++; if (w_done_n != 1 || w_done_cyc != 11) begin
            failures++; $display("FAIL pub_done got=%0d n=%0d want=11 n=1", w_done_cyc, w_done_n); end
        checks++; if (w_busy_n != 11 || w_busy_hi != 11) begin
            failures++; $display("FAIL pub_busy got=n%0d end%0d want=n11 end11", w_busy_n, w_busy_hi); end
        checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL pub_overrun got=%b want=1", bus.overrun); end
        checks++; if (bus.y_bus !== e) begin failures++; $display("FAIL pub_bank got=%h want=%h", bus.y_bus, e); end
        exp_y = e;
    endtask

    task automatic test_random();
        logic [XW-1:0]   x;
        logic [YW-1:0]   e;
        logic [N_CH-1:0] m;
        int              d;
        for (int it = 0; it < 5; it++) begin
            x = rand_x();
`ifdef SEQ_CH_MASK_EN
            m = N_CH'($urandom());
`else
            m = '1;
`endif
            e = model_bank(x, m, exp_y);
            d = model_done(m);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            start(x, m);
            watch(d + 2, exp_y, -1, -1, '0, -1, -1);
            checks++; if (w_done_cyc != d || w_done_n != 1) begin
                failures++; $display("FAIL rand_done it=%0d mask=%h got=%0d n=%0d want=%0d", it, last_mask, w_done_cyc, w_done_n, d); end
            checks++; if (w_y_done !== e || w_y_early) begin
                failures++; $display("FAIL rand_bank it=%0d got=%h want=%h early=%0d", it, w_y_done, e, w_y_early); end
            exp_y = e;
        end
    endtask

`ifdef SEQ_CH_MASK_EN
    task automatic test_mask();
        logic [XW-1:0]   x;
        logic [YW-1:0]   e;
        logic [N_CH-1:0] m;
        int              j;
        x = rand_x();
        m = N_CH'(8'h05);
        e = model_bank(x, m, exp_y);
        start(x, m);
        watch(8, exp_y, -1, -1, '0, -1, -1);
        checks++; if (w_done_cyc != 5) begin failures++; $display("FAIL mask_done got=%0d want=5", w_done_cyc); end
        checks++; if (w_busy_hi != 5) begin failures++; $display("FAIL mask_busy_end got=%0d want=5", w_busy_hi); end
        checks++; if (w_y_done !== e) begin failures++; $display("FAIL mask_bank got=%h want=%h", w_y_done, e); end
        j = 0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (m[k]) begin
                checks++; if (w_cx[1+j] !== x[k*SW +: SW]) begin
                    failures++; $display("FAIL mask_conv_x ch=%0d got=%h want=%h", k, w_cx[1+j], x[k*SW +: SW]); end
                j++;
            end
        end
        exp_y = e;
    endtask

    task automatic test_mask_zero();
        start(rand_x(), '0);
        watch(5, exp_y, -1, -1, '0, -1, -1);
        checks++; if (w_done_cyc != 1 || w_done_n != 1) begin
            failures++; $display("FAIL mask0_done got=%0d n=%0d want=1 n=1", w_done_cyc, w_done_n); end
        checks++; if (w_y_done !== exp_y) begin failures++; $display("FAIL mask0_bank got=%h want=%h", w_y_done, exp_y); end
        checks++; if (w_busy_n != 1) begin failures++; $display("FAIL mask0_busy got=%0d want=1", w_busy_n); end
    endtask
`endif

    initial begin
        bus.sta   = 1'b0;
        bus.x_bus = '0;
`ifdef SEQ_CH_MASK_EN
        bus.ch_mask = '0;
`endif
        exp_y     = '0;
        last_mask = '0;
        test_reset();
        test_basic();
        test_x_change();
        test_back_to_back();
        test_overrun();
        test_mid_reset();
        test_publish_sta();
        test_random();
`ifdef SEQ_CH_MASK_EN
        test_mask();
        test_mask_zero();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
